// File: rtl/iter_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : iter_shift_ctrl
// Purpose  : Multi-cycle execute-stage shifter. Performs sll/srl/sra/rol by
//            iterating a fixed 2-bit step, with a final 1-bit step for odd
//            shift amounts, instead of using a full barrel shifter.
//            Uses a start/busy/done handshake and raises a stall request
//            while an operation is in flight. Flush aborts without a result.
// Ports    : clk      - system clock, rising edge
//            reset    - synchronous, active-low reset
//            start    - request a new operation (accepted in IDLE or DONE)
//            op       - 00 sll, 01 srl, 10 sra, 11 rol
//            in_data  - operand to shift
//            shamt    - shift amount, 0..WIDTH-1
//            flush    - abort the current operation
//            busy     - high while shifting
//            done     - one-cycle pulse, result valid
//            stall    - busy | (start & ready to accept), combinational
//            result   - last completed result, held until next completion
// Revision : 1.0 - initial release
// ============================================================================
module iter_shift_ctrl #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   shamt,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] result
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    localparam logic [1:0] c_op_sll = 2'b00;
    localparam logic [1:0] c_op_srl = 2'b01;
    localparam logic [1:0] c_op_sra = 2'b10;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_acc;
    logic [1:0]       r_op;
    logic [SHW-1:0]   r_rem;
    logic [WIDTH-1:0] r_result;

    logic             w_ready;
    logic             w_accept;
    logic             w_by_two;
    logic [WIDTH-1:0] w_step_acc;
    logic [SHW-1:0]   w_rem_next;

    // A new operation may only be taken when nothing is in flight; flush
    // always cancels a simultaneous start.
    assign w_ready  = (r_state == c_st_idle) || (r_state == c_st_done);
    assign w_accept = w_ready && start && !flush;
    assign stall    = busy || (start && w_ready);
    assign result   = r_result;

    // One iteration of the shifter: a 2-bit step while at least two
    // positions remain, otherwise the trailing 1-bit step.
    always_comb begin
        w_by_two   = (r_rem >= SHW'(2));
        w_step_acc = r_acc;
        w_rem_next = '0;
        if (w_by_two) begin
            w_rem_next = r_rem - SHW'(2);
        end
        case (r_op)
            c_op_sll: w_step_acc = w_by_two ? {r_acc[WIDTH-3:0], 2'b00}
                                            : {r_acc[WIDTH-2:0], 1'b0};
            c_op_srl: w_step_acc = w_by_two ? {2'b00, r_acc[WIDTH-1:2]}
                                            : {1'b0, r_acc[WIDTH-1:1]};
            // Sign fill comes from the current accumulator MSB, so repeated
            // steps compose into a single arithmetic shift.
            c_op_sra: w_step_acc = w_by_two ? {{2{r_acc[WIDTH-1]}}, r_acc[WIDTH-1:2]}
                                            : {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
            default:  w_step_acc = w_by_two ? {r_acc[WIDTH-3:0], r_acc[WIDTH-1:WIDTH-2]}
                                            : {r_acc[WIDTH-2:0], r_acc[WIDTH-1]};
        endcase
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        busy         = (r_state == c_st_shift);
        done         = (r_state == c_st_done);
        case (r_state)
            c_st_idle, c_st_done: begin
                if (w_accept) begin
                    w_next_state = (shamt == '0) ? c_st_done : c_st_shift;
                end else begin
                    w_next_state = c_st_idle;
                end
            end
            c_st_shift: begin
                if (w_rem_next == '0) begin
                    w_next_state = c_st_done;
                end
            end
            default: w_next_state = c_st_idle;
        endcase
        if (flush) begin
            w_next_state = c_st_idle;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= c_st_idle;
            r_acc    <= '0;
            r_op     <= '0;
            r_rem    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_acc <= in_data;
                r_op  <= op;
                r_rem <= shamt;
                // A zero shift completes immediately with the operand.
                if (shamt == '0) begin
                    r_result <= in_data;
                end
            end else if ((r_state == c_st_shift) && !flush) begin
                r_acc <= w_step_acc;
                r_rem <= w_rem_next;
                if (w_rem_next == '0) begin
                    r_result <= w_step_acc;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iter_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_iter_shift_ctrl
// Purpose  : Self-checking bench for iter_shift_ctrl. Directed cases plus
//            random operations compared against an arithmetic shift model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iter_shift_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] in_data;
    logic [4:0]  shamt;
    logic        flush;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] result;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iter_shift_ctrl #(.WIDTH(32), .SHW(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .in_data (in_data),
        .shamt   (shamt),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .stall   (stall),
        .result  (result)
    );

    // Whole-operation reference: the final value of an iterated shift is the
    // plain single shift by the full amount.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d, input int s);
        logic signed [31:0] sd;
        sd = d;
        case (o)
            2'd0:    return d << s;
            2'd1:    return d >> s;
            2'd2:    return sd >>> s;
            default: return (s == 0) ? d : ((d << s) | (d >> (32 - s)));
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts an operation from IDLE or DONE and follows it to its done pulse.
    // Returns with time just after the edge that raised done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] d, input int s, input string tag);
        logic [31:0] exp_r;
        int          exp_lat;
        int          lat;
        exp_r   = model(o, d, s);
        exp_lat = (s + 1) / 2;
        op      = o;
        in_data = d;
        shamt   = 5'(s);
        start   = 1'b1;
        #1;
        check({tag, "_stall_req"}, 32'(stall), 32'd1);
        tick();
        start   = 1'b0;
        op      = 2'($urandom);
        in_data = $urandom;
        shamt   = 5'($urandom);
        lat     = 0;
        while (!done && lat < 40) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        check({tag, "_result"}, result, exp_r);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] prev;
        int          seen;
        reset   = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        op      = 2'd0;
        in_data = 32'd0;
        shamt   = 5'd0;

        // Reset state, and start ignored while reset is low.
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        start   = 1'b1;
        in_data = 32'h12345678;
        tick();
        check("rst_start_busy", 32'(busy), 32'd0);
        check("rst_start_done", 32'(done), 32'd0);
        start = 1'b0;
        reset = 1'b1;
        tick();
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_result", result, 32'd0);

        // Directed operations.
        run_op(2'd0, 32'h00000001, 5, "sll5");
        tick();
        check("hold_done_drop", 32'(done), 32'd0);
        check("hold_result", result, 32'h00000020);
        run_op(2'd2, 32'h80000000, 31, "sra31");
        tick();
        run_op(2'd1, 32'h80000000, 31, "srl31");
        tick();
        run_op(2'd0, 32'h12345678, 0, "zero_sll");
        tick();
        run_op(2'd3, 32'h12345678, 0, "zero_rol");
        tick();
        run_op(2'd3, 32'h80000001, 4, "rol4");
        // Back-to-back start taken in the DONE cycle.
        run_op(2'd0, 32'h00000001, 2, "b2b_sll2");
        tick();

        // Flush mid-operation; a start while busy is ignored.
        prev    = result;
        op      = 2'd1;
        in_data = 32'hFFFF0000;
        shamt   = 5'd20;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("fl_busy1", 32'(busy), 32'd1);
        start   = 1'b1;
        op      = 2'd0;
        in_data = 32'h00000001;
        shamt   = 5'd0;
        tick();
        start = 1'b0;
        check("fl_ignored_busy", 32'(busy), 32'd1);
        check("fl_ignored_done", 32'(done), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_busy", 32'(busy), 32'd0);
        check("fl_done", 32'(done), 32'd0);
        check("fl_result", result, prev);
        seen = 0;
        repeat (12) begin
            tick();
            if (done || busy) seen = 1;
        end
        check("fl_no_later_done", 32'(seen), 32'd0);

        // Flush wins over a simultaneous start.
        start = 1'b1;
        flush = 1'b1;
        shamt = 5'd0;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("flst_busy", 32'(busy), 32'd0);
        check("flst_done", 32'(done), 32'd0);
        check("flst_result", result, prev);

        // Reset asserted mid-shift.
        op      = 2'd2;
        in_data = 32'h80000000;
        shamt   = 5'd31;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset   = 1'b0;
        start   = 1'b1;
        shamt   = 5'd0;
        tick();
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_result", result, 32'd0);
        tick();
        reset = 1'b1;
        start = 1'b0;
        tick();
        check("mrst_not_accepted", 32'(done | busy), 32'd0);

        // Random operations, with and without an idle gap between them.
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom), $urandom, int'($urandom_range(0, 31)), "rand");
            if ($urandom_range(0, 1) == 1) begin
                tick();
                check("rand_idle", 32'(done | busy), 32'd0);
            end
        end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
